// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters; optional STARVE_GUARD_EN
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int MAX_D_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_mem_enable,
    input  logic [31:0] i_address,
    input  logic [1:0]  i_access_size,
    output logic [31:0] i_data,
    output logic        i_valid,
    output logic        fetch_stall,
    input  logic        d_mem_enable,
    input  logic        d_rw,
    input  logic [31:0] d_address,
    input  logic [1:0]  d_access_size,
    input  logic [31:0] d_data_in,
    output logic [31:0] d_data,
    output logic        d_valid,
    output logic        mem_stall,
    output logic        m_enable,
    output logic        m_rw,
    output logic [31:0] m_address,
    output logic [1:0]  m_access_size,
    output logic [31:0] m_data_in,
    input  logic [31:0] m_data_out
);
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        m_enable_q, m_enable_d, m_rw_q, m_rw_d;
    logic [31:0] m_address_q, m_address_d, m_data_in_q, m_data_in_d;
    logic [1:0]  m_size_q, m_size_d;
    logic [31:0] i_data_q, i_data_d, d_data_q, d_data_d;
    logic        starve, pick_i;

`ifdef STARVE_GUARD_EN
    localparam int BW = $clog2(MAX_D_BURST + 1);
    logic [BW-1:0] burst_q, burst_d;
    assign starve = (burst_q == BW'(MAX_D_BURST));
`else
    assign starve = 1'b0;
`endif

    assign pick_i      = i_mem_enable & (~d_mem_enable | starve);
    assign i_valid     = (state_q == DONE_I);
    assign d_valid     = (state_q == DONE_D);
    assign fetch_stall = i_mem_enable & ~i_valid;
    assign mem_stall   = d_mem_enable & ~d_valid;
    assign i_data        = i_data_q;
    assign d_data        = d_data_q;
    assign m_enable      = m_enable_q;
    assign m_rw          = m_rw_q;
    assign m_address     = m_address_q;
    assign m_access_size = m_size_q;
    assign m_data_in     = m_data_in_q;

    // grant selection in IDLE, latency countdown while BUSY, one-cycle DONE pulse
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_enable_d  = 1'b0;
        m_rw_d      = m_rw_q;
        m_address_d = m_address_q;
        m_size_d    = m_size_q;
        m_data_in_d = m_data_in_q;
        i_data_d    = i_data_q;
        d_data_d    = d_data_q;
`ifdef STARVE_GUARD_EN
        burst_d     = burst_q;
`endif
        case (state_q)
            IDLE: if (d_mem_enable | i_mem_enable) begin
                state_d     = pick_i ? BUSY_I : BUSY_D;
                cnt_d       = 4'(MEM_LATENCY);
                m_enable_d  = 1'b1;
                m_rw_d      = pick_i ? 1'b1 : d_rw;
                m_address_d = pick_i ? i_address : d_address;
                m_size_d    = pick_i ? i_access_size : d_access_size;
                m_data_in_d = pick_i ? m_data_in_q : d_data_in;
`ifdef STARVE_GUARD_EN
                burst_d     = pick_i ? '0 : (starve ? burst_q : burst_q + BW'(1));
`endif
            end
            BUSY_I: begin
                cnt_d    = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
                state_d  = (cnt_q == 4'd0) ? DONE_I : BUSY_I;
                i_data_d = (cnt_q == 4'd0) ? m_data_out : i_data_q;
            end
            BUSY_D: begin
                cnt_d    = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
                state_d  = (cnt_q == 4'd0) ? DONE_D : BUSY_D;
                d_data_d = (cnt_q == 4'd0 && m_rw_q) ? m_data_out : d_data_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            m_enable_q  <= 1'b0;
            m_rw_q      <= 1'b1;
            m_address_q <= '0;
            m_size_q    <= '0;
            m_data_in_q <= '0;
            i_data_q    <= '0;
            d_data_q    <= '0;
`ifdef STARVE_GUARD_EN
            burst_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_enable_q  <= m_enable_d;
            m_rw_q      <= m_rw_d;
            m_address_q <= m_address_d;
            m_size_q    <= m_size_d;
            m_data_in_q <= m_data_in_d;
            i_data_q    <= i_data_d;
            d_data_q    <= d_data_d;
`ifdef STARVE_GUARD_EN
            burst_q     <= burst_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a latency-modelled memory
module tb_mem_port_arbiter;
    localparam int L = 2;

    logic        clock = 1'b0, reset = 1'b1;
    logic        i_mem_enable = 1'b0, d_mem_enable = 1'b0, d_rw = 1'b1;
    logic [31:0] i_address = '0, d_address = '0, d_data_in = '0;
    logic [1:0]  i_access_size = '0, d_access_size = '0;
    logic [31:0] i_data, d_data, m_address, m_data_in, m_data_out;
    logic        i_valid, d_valid, fetch_stall, mem_stall, m_enable, m_rw;
    logic [1:0]  m_access_size;

    typedef struct { logic is_d; logic [31:0] data; } exp_t;
    exp_t        exp_q[$];
    int          checks = 0, errors = 0, m_cnt = 0, icnt = 0;
    logic        last_rw = 1'b1;
    logic [31:0] last_wd = '0, last_d = '0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] pipe [L];

    mem_port_arbiter #(.MEM_LATENCY(L), .MAX_D_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .i_mem_enable(i_mem_enable), .i_address(i_address), .i_access_size(i_access_size),
        .i_data(i_data), .i_valid(i_valid), .fetch_stall(fetch_stall),
        .d_mem_enable(d_mem_enable), .d_rw(d_rw), .d_address(d_address),
        .d_access_size(d_access_size), .d_data_in(d_data_in), .d_data(d_data),
        .d_valid(d_valid), .mem_stall(mem_stall),
        .m_enable(m_enable), .m_rw(m_rw), .m_address(m_address),
        .m_access_size(m_access_size), .m_data_in(m_data_in), .m_data_out(m_data_out)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // memory model: read word appears L cycles after the strobe
    assign m_data_out = pipe[L-1];
    always @(posedge clock) begin
        for (int k = L - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        if (m_enable) begin
            pipe[0] <= pat(m_address);
            if (!m_rw) mem[m_address] = m_data_in;
        end
    end

    // monitor: strobe capture and scoreboard pop on every valid pulse
    always @(negedge clock) begin
        exp_t e;
        if (m_enable) begin
            m_cnt++;
            last_rw = m_rw;
            last_wd = m_data_in;
        end
        if (i_valid) icnt++;
        if (i_valid || d_valid) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("kind", {31'd0, d_valid}, {31'd0, e.is_d});
                chk("data", d_valid ? d_data : i_data, e.data);
            end
        end
    end

    task automatic push(input logic is_d, input logic [31:0] data);
        exp_q.push_back('{is_d, data});
        if (is_d) last_d = data;
    endtask

    task automatic serve();
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (d_valid) d_mem_enable = 1'b0;
            if (i_valid) i_mem_enable = 1'b0;
            if (!d_mem_enable && !i_mem_enable) return;
        end
        chk("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int base, lat, done;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_m_enable", {31'd0, m_enable}, 32'd0);
        chk("rst_m_rw", {31'd0, m_rw}, 32'd1);
        chk("rst_m_address", m_address, 32'd0);
        chk("rst_valids", {30'd0, i_valid, d_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // single fetch: latency, strobe count, stall window
        base = m_cnt;
        i_address = 32'h8002_0000;
        push(1'b0, pat(32'h8002_0000));
        i_mem_enable = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            lat = k;
            if (i_valid) break;
            chk("fetch_stall_hi", {31'd0, fetch_stall}, 32'd1);
        end
        chk("fetch_latency", lat, 32'd4);
        chk("fetch_stall_lo", {31'd0, fetch_stall}, 32'd0);
        i_mem_enable = 1'b0;
        @(negedge clock);
        chk("fetch_strobes", m_cnt - base, 32'd1);
        chk("fetch_rw", {31'd0, last_rw}, 32'd1);

        // simultaneous: data first, then fetch
        base = m_cnt;
        i_address = 32'h8002_0004;
        d_address = 32'h8003_0000;
        d_rw = 1'b1;
        push(1'b1, pat(32'h8003_0000));
        push(1'b0, pat(32'h8002_0004));
        i_mem_enable = 1'b1;
        d_mem_enable = 1'b1;
        serve();
        repeat (2) @(negedge clock);
        chk("dual_strobes", m_cnt - base, 32'd2);

        // write then read back
        d_address = 32'h8003_0010;
        d_data_in = 32'hDEAD_BEEF;
        d_rw = 1'b0;
        push(1'b1, last_d);
        d_mem_enable = 1'b1;
        serve();
        chk("wr_rw", {31'd0, last_rw}, 32'd0);
        chk("wr_data_in", last_wd, 32'hDEAD_BEEF);
        d_rw = 1'b1;
        push(1'b1, 32'hDEAD_BEEF);
        d_mem_enable = 1'b1;
        serve();

        // reset during BUSY_D aborts the access
        d_address = 32'h8003_0000;
        push(1'b1, 32'h0);
        d_mem_enable = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        d_mem_enable = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("abort_m_enable", {31'd0, m_enable}, 32'd0);
        chk("abort_m_rw", {31'd0, m_rw}, 32'd1);
        chk("abort_m_address", m_address, 32'd0);
        chk("abort_m_data_in", m_data_in, 32'd0);
        chk("abort_d_data", d_data, 32'd0);
        chk("abort_i_data", i_data, 32'd0);
        chk("abort_d_valid", {31'd0, d_valid}, 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clock);

        // fetch drops enable while busy: still completes exactly once
        base = icnt;
        i_address = 32'h8002_0008;
        push(1'b0, pat(32'h8002_0008));
        i_mem_enable = 1'b1;
        repeat (2) @(negedge clock);
        i_mem_enable = 1'b0;
        repeat (8) @(negedge clock);
        chk("drop_ivalid_count", icnt - base, 32'd1);
        chk("drop_fetch_stall", {31'd0, fetch_stall}, 32'd0);

        // continuous contention: grant order depends on the starvation guard
        d_address = 32'h8003_0020;
        for (int n = 0; n < 10; n++) begin
`ifdef STARVE_GUARD_EN
            push((n % 5) != 4, (n % 5) != 4 ? pat(32'h8003_0020) : pat(32'h8002_0008));
`else
            push(1'b1, pat(32'h8003_0020));
`endif
        end
        i_mem_enable = 1'b1;
        d_mem_enable = 1'b1;
        done = 0;
        for (int k = 0; k < 400 && done < 10; k++) begin
            @(negedge clock);
            if (i_valid || d_valid) done++;
        end
        i_mem_enable = 1'b0;
        d_mem_enable = 1'b0;
        chk("burst_done", done, 32'd10);
        repeat (8) @(negedge clock);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
